csi_segment_evaluator: RTL and testbench



---
 rtl/csi_pkg.sv | 37 +++
 rtl/csi_segment_evaluator_mac.sv | 28 ++
 rtl/csi_segment_evaluator.sv | 191 +++++++++++++++++++
 tb/tb_csi_segment_evaluator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared types and helpers for the cubic-spline segment evaluator.
package csi_pkg;

    localparam int unsigned CSI_W   = 20;
    localparam int unsigned CLAMP_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        MUL1,
        MUL2,
        MUL3,
        OUT
    } state_e;

    // Clamp a sign-extended 2W+1-bit sum to the signed range of a w-bit value.
    function automatic logic signed [CLAMP_W-1:0] sat_clamp(
        input  logic signed [CLAMP_W-1:0] sum,
        input  int unsigned               w,
        output logic                      ovf
    );
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        ovf = 1'b0;
        if (sum > hi) begin
            ovf = 1'b1;
            return hi;
        end
        if (sum < lo) begin
            ovf = 1'b1;
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/csi_segment_evaluator_mac.sv
// Combinational Horner step: acc*t + coef, clamped to W bits with overflow flag.
import csi_pkg::*;

module csi_mac_sat #(
    parameter int unsigned W = CSI_W
) (
    input  logic signed [W-1:0] acc_i,
    input  logic signed [W-1:0] t_i,
    input  logic signed [W-1:0] coef_i,
    output logic signed [W-1:0] res_c_o,
    output logic                sat_c_o
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned SW = 2 * W + 1;

    logic signed [PW-1:0]      prod;
    logic signed [SW-1:0]      sum;
    logic signed [CLAMP_W-1:0] clamped;

    always_comb begin
        prod    = PW'(acc_i) * PW'(t_i);
        sum     = SW'(prod) + SW'(coef_i);
        clamped = sat_clamp(CLAMP_W'(sum), W, sat_c_o);
        res_c_o = W'(clamped);
    end

endmodule

// File: rtl/csi_segment_evaluator.sv
// Evaluates one cubic segment at every integer position in [P_lo, P_hi) and streams samples.
import csi_pkg::*;

module csi_segment_evaluator #(
    parameter int unsigned W = CSI_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                seg_valid,
    output logic                seg_ready,
    input  logic signed [W-1:0] seg_a,
    input  logic signed [W-1:0] seg_b,
    input  logic signed [W-1:0] seg_c,
    input  logic signed [W-1:0] seg_d,
    input  logic signed [W-1:0] seg_p_lo,
    input  logic signed [W-1:0] seg_p_hi,
    output logic                y_valid,
    input  logic                y_ready,
    output logic signed [W-1:0] y_data,
    output logic signed [W-1:0] y_pos,
    output logic                y_last,
    output logic                y_sat,
    output logic                seg_done
);

    state_e state_q, state_d;

    logic signed [W-1:0] acc_q, acc_d;
    logic signed [W-1:0] t_q, t_d;
    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic signed [W-1:0] p_hi_q, p_hi_d;
    logic                sat_q, sat_d;

    logic                seg_ready_q, seg_ready_d;
    logic                y_valid_q, y_valid_d;
    logic signed [W-1:0] y_data_q, y_data_d;
    logic signed [W-1:0] y_pos_q, y_pos_d;
    logic                y_last_q, y_last_d;
    logic                y_sat_q, y_sat_d;
    logic                seg_done_q, seg_done_d;

    logic signed [W-1:0] coef_sel;
    logic signed [W-1:0] mac_res;
    logic                mac_sat;

    // Single shared multiplier; the state picks which coefficient is added.
    always_comb begin
        coef_sel = a_q;
        case (state_q)
            MUL1:    coef_sel = c_q;
            MUL2:    coef_sel = b_q;
            default: coef_sel = a_q;
        endcase
    end

    csi_mac_sat #(.W(W)) u_mac (
        .acc_i   (acc_q),
        .t_i     (t_q),
        .coef_i  (coef_sel),
        .res_c_o (mac_res),
        .sat_c_o (mac_sat)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        t_d        = t_q;
        x_d        = x_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        p_hi_d     = p_hi_q;
        sat_d      = sat_q;
        y_valid_d  = y_valid_q;
        y_data_d   = y_data_q;
        y_pos_d    = y_pos_q;
        y_last_d   = y_last_q;
        y_sat_d    = y_sat_q;
        seg_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (seg_valid) begin
                    a_d    = seg_a;
                    b_d    = seg_b;
                    c_d    = seg_c;
                    d_d    = seg_d;
                    p_hi_d = seg_p_hi;
                    t_d    = '0;
                    x_d    = seg_p_lo;
                    if (seg_p_hi <= seg_p_lo) begin
                        seg_done_d = 1'b1;
                    end else begin
                        acc_d   = seg_d;
                        sat_d   = 1'b0;
                        state_d = MUL1;
                    end
                end
            end
            MUL1: begin
                acc_d   = mac_res;
                sat_d   = sat_q | mac_sat;
                state_d = MUL2;
            end
            MUL2: begin
                acc_d   = mac_res;
                sat_d   = sat_q | mac_sat;
                state_d = MUL3;
            end
            MUL3: begin
                acc_d     = mac_res;
                sat_d     = sat_q | mac_sat;
                y_valid_d = 1'b1;
                y_data_d  = mac_res;
                y_pos_d   = x_q;
                y_last_d  = (x_q == (p_hi_q - W'(1)));
                y_sat_d   = sat_q | mac_sat;
                state_d   = OUT;
            end
            OUT: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    if (y_last_q) begin
                        seg_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        t_d     = t_q + W'(1);
                        x_d     = x_q + W'(1);
                        acc_d   = d_q;
                        sat_d   = 1'b0;
                        state_d = MUL1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        seg_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            t_q         <= '0;
            x_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            p_hi_q      <= '0;
            sat_q       <= 1'b0;
            seg_ready_q <= 1'b1;
            y_valid_q   <= 1'b0;
            y_data_q    <= '0;
            y_pos_q     <= '0;
            y_last_q    <= 1'b0;
            y_sat_q     <= 1'b0;
            seg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            t_q         <= t_d;
            x_q         <= x_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            p_hi_q      <= p_hi_d;
            sat_q       <= sat_d;
            seg_ready_q <= seg_ready_d;
            y_valid_q   <= y_valid_d;
            y_data_q    <= y_data_d;
            y_pos_q     <= y_pos_d;
            y_last_q    <= y_last_d;
            y_sat_q     <= y_sat_d;
            seg_done_q  <= seg_done_d;
        end
    end

    assign seg_ready = seg_ready_q;
    assign y_valid   = y_valid_q;
    assign y_data    = y_data_q;
    assign y_pos     = y_pos_q;
    assign y_last    = y_last_q;
    assign y_sat     = y_sat_q;
    assign seg_done  = seg_done_q;

endmodule

// File: tb/tb_csi_segment_evaluator.sv
// Directed bench for csi_segment_evaluator: scoreboarded samples plus timing and reset checks.
module tb_csi_segment_evaluator;

    localparam int W = 20;
    localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W - 1));

    typedef struct {
        logic signed [W-1:0] data;
        logic signed [W-1:0] pos;
        logic                last;
        logic                sat;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                seg_valid;
    logic                seg_ready;
    logic signed [W-1:0] seg_a, seg_b, seg_c, seg_d, seg_p_lo, seg_p_hi;
    logic                y_valid;
    logic                y_ready;
    logic signed [W-1:0] y_data, y_pos;
    logic                y_last, y_sat, seg_done;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   done_expect_cyc = -1;
    int   n_done   = 0;
    int   n_hs     = 0;
    int   exp_done = 0;
    bit   first_pending = 1'b0;

    csi_segment_evaluator #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_valid(seg_valid),
        .seg_ready(seg_ready),
        .seg_a    (seg_a),
        .seg_b    (seg_b),
        .seg_c    (seg_c),
        .seg_d    (seg_d),
        .seg_p_lo (seg_p_lo),
        .seg_p_hi (seg_p_hi),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_data   (y_data),
        .y_pos    (y_pos),
        .y_last   (y_last),
        .y_sat    (y_sat),
        .seg_done (seg_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference Horner evaluation with clamping after every step.
    task automatic push_seg(input int a, input int b, input int c, input int d, input int plo, input int phi);
        longint co[3];
        co[0] = c; co[1] = b; co[2] = a;
        for (int x = plo; x < phi; x++) begin
            exp_t   e;
            longint t   = longint'(x - plo);
            longint acc = d;
            bit     s   = 1'b0;
            for (int k = 0; k < 3; k++) begin
                acc = acc * t + co[k];
                if (acc > MAXV) begin acc = MAXV; s = 1'b1; end
                else if (acc < MINV) begin acc = MINV; s = 1'b1; end
            end
            e.data = W'(acc);
            e.pos  = W'(x);
            e.last = (x == phi - 1);
            e.sat  = s;
            sb.push_back(e);
        end
    endtask

    task automatic send(input int a, input int b, input int c, input int d, input int plo, input int phi);
        push_seg(a, b, c, d, plo, phi);
        seg_a = W'(a); seg_b = W'(b); seg_c = W'(c); seg_d = W'(d);
        seg_p_lo = W'(plo); seg_p_hi = W'(phi);
        seg_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (seg_ready) break;
            tick;
        end
        check("seg_accept_ready", seg_ready, 1);
        tick;
        seg_valid = 1'b0;
        seg_a = W'($urandom); seg_b = W'($urandom); seg_c = W'($urandom); seg_d = W'($urandom);
        seg_p_lo = W'($urandom); seg_p_hi = W'($urandom);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_done >= target) break;
            tick;
        end
        check("seg_done_count", n_done, target);
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (n_hs >= target) break;
            tick;
        end
        check("handshake_count", n_hs, target);
    endtask

    // Monitor: scoreboard pops on output handshakes, latency and seg_done timing.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (seg_done) begin
                check("seg_done_cycle", cyc, done_expect_cyc);
                n_done++;
            end
            if (y_valid && first_pending) begin
                check("first_latency", cyc - acc_cyc, 4);
                first_pending = 1'b0;
            end
            if (seg_valid && seg_ready) begin
                acc_cyc = cyc;
                if (seg_p_hi <= seg_p_lo) done_expect_cyc = cyc + 1;
                else first_pending = 1'b1;
            end
            if (y_valid && y_ready) begin
                n_hs++;
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("y_data", y_data, e.data);
                    check("y_pos",  y_pos,  e.pos);
                    check("y_last", y_last, e.last);
                    check("y_sat",  y_sat,  e.sat);
                    if (e.last) done_expect_cyc = cyc + 1;
                end
            end
        end
    end

    initial begin
        int hs0;
        rst = 1'b1; seg_valid = 1'b0; y_ready = 1'b1;
        seg_a = '0; seg_b = '0; seg_c = '0; seg_d = '0; seg_p_lo = '0; seg_p_hi = '0;
        tick; tick;
        check("rst_seg_ready", seg_ready, 1);
        check("rst_y_valid",   y_valid,   0);
        check("rst_y_data",    y_data,    0);
        check("rst_y_pos",     y_pos,     0);
        check("rst_y_last",    y_last,    0);
        check("rst_y_sat",     y_sat,     0);
        check("rst_seg_done",  seg_done,  0);
        rst = 1'b0;
        tick;
        check("idle_seg_ready", seg_ready, 1);

        // Linear segment
        send(100, 5, 0, 0, 10, 14);
        exp_done++; wait_done(exp_done, 60);

        // Pure cubic
        send(0, 0, 0, 1, 0, 4);
        exp_done++; wait_done(exp_done, 60);

        // Backpressure on the second sample
        hs0 = n_hs;
        send(100, 5, 0, 0, 10, 14);
        wait_hs(hs0 + 1, 40);
        y_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (y_valid) break;
            tick;
        end
        check("bp_valid", y_valid, 1);
        for (int i = 0; i < 6; i++) begin
            check("bp_hold_data",  y_data,  105);
            check("bp_hold_pos",   y_pos,   11);
            check("bp_hold_valid", y_valid, 1);
            tick;
        end
        y_ready = 1'b1;
        exp_done++; wait_done(exp_done, 60);

        // Positive saturation from t = 9 onward
        send(0, 0, 0, 1000, 0, 100);
        exp_done++; wait_done(exp_done, 1000);

        // Empty segment
        send(0, 0, 0, 0, 7, 7);
        exp_done++;
        check("empty_seg_done",  seg_done,  1);
        check("empty_seg_ready", seg_ready, 1);
        check("empty_no_valid",  y_valid,   0);
        wait_done(exp_done, 10);

        // Signed positions, negative coefficients, negative clamp
        send(-1234, -3, 17, -1000, -2, 11);
        exp_done++; wait_done(exp_done, 200);

        // Reset during MUL2 of the third sample
        hs0 = n_hs;
        send(7, 3, 2, 1, 0, 10);
        wait_hs(hs0 + 2, 60);
        tick;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_y_valid",   y_valid,   0);
        check("mid_rst_y_data",    y_data,    0);
        check("mid_rst_y_pos",     y_pos,     0);
        check("mid_rst_y_last",    y_last,    0);
        check("mid_rst_y_sat",     y_sat,     0);
        check("mid_rst_seg_done",  seg_done,  0);
        check("mid_rst_seg_ready", seg_ready, 1);
        sb.delete();
        first_pending = 1'b0;
        tick; tick;
        rst = 1'b0;
        tick; tick;
        check("no_done_on_reset", n_done, exp_done);

        send(3, -2, 1, 1, -3, 2);
        exp_done++; wait_done(exp_done, 60);

        tick; tick;
        check("sb_empty",   sb.size(), 0);
        check("done_total", n_done,    exp_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
